// File: rtl/demux_rr_dispatch_if.sv
// Bundle of the source-side handshake and the lane-side bus of the
// round-robin / directed demux dispatcher. The dispatcher takes the
// slave view. The producer/consumer environment takes the master view.
interface demux_rr_dispatch_if #(
  parameter int NUM_OUT = 2,
  parameter int DATA_W  = 8,
  parameter int SEL_W   = (NUM_OUT <= 2) ? 1 : $clog2(NUM_OUT)
);

  logic               in_valid;
  logic               in_ready;
  logic [DATA_W-1:0]  in_data;
  logic [SEL_W-1:0]   in_sel;
  logic               rr_mode;
  logic [NUM_OUT-1:0] out_valid;
  logic [NUM_OUT-1:0] out_ready;
  logic [DATA_W-1:0]  out_data;
  logic [SEL_W-1:0]   cur_sel;
  logic               busy;
  logic [7:0]         drop_cnt;

  modport master (
    output in_valid, in_data, in_sel, rr_mode, out_ready,
    input  in_ready, out_valid, out_data, cur_sel, busy, drop_cnt
  );

  modport slave (
    input  in_valid, in_data, in_sel, rr_mode, out_ready,
    output in_ready, out_valid, out_data, cur_sel, busy, drop_cnt
  );

endinterface

// File: rtl/demux_rr_dispatch.sv
// demux_rr_dispatch: sequences a 1:NUM_OUT demux.
// It accepts one word in IDLE and holds it on a single lane until that lane
// takes it, or until TIMEOUT stalled cycles pass and the word is dropped.
// The lane is the requested in_sel (directed) or an internal round-robin pointer.
// Optional macro DISPATCH_STATS_EN adds per-lane delivery counters
// (lane_cnt) and their synchronous clear (stats_clr).
module demux_rr_dispatch #(
  parameter int NUM_OUT = 2,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 15,
  parameter int SEL_W   = (NUM_OUT <= 2) ? 1 : $clog2(NUM_OUT)
) (
  input  logic                   clk,
  input  logic                   rst,
  demux_rr_dispatch_if.slave     bus
`ifdef DISPATCH_STATS_EN
  ,
  input  logic                   stats_clr,
  output logic [NUM_OUT*8-1:0]   lane_cnt
`endif
);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_next_state;

  logic [DATA_W-1:0]  r_out_data;
  logic [NUM_OUT-1:0] r_out_valid;
  logic [SEL_W-1:0]   r_target;
  logic [SEL_W-1:0]   r_rr_ptr;
  logic               r_rr_word;
  logic [7:0]         r_wait_cnt;
  logic [7:0]         r_drop_cnt;

  logic               w_in_ready;
  logic               w_accept;
  logic               w_sel_oob;
  logic               w_load;
  logic               w_transfer;
  logic               w_timeout;
  logic               w_leave_hold;
  logic               w_drop;
  logic               w_ptr_adv;
  logic [SEL_W-1:0]   w_req_sel;
  logic [SEL_W-1:0]   w_ptr_inc;

  // The directed select is out of range when it names a lane that does not exist.
  assign w_sel_oob = ({1'b0, bus.in_sel} >= (SEL_W+1)'(NUM_OUT));
  assign w_req_sel = bus.rr_mode ? r_rr_ptr : bus.in_sel;
  assign w_ptr_inc = (r_rr_ptr == SEL_W'(NUM_OUT-1)) ? '0 : r_rr_ptr + 1'b1;

  // State register. Reset returns to IDLE and discards any held word.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next state and per-cycle strobes. A transfer beats a coincident timeout.
  always_comb begin
    w_next_state = r_state;
    w_in_ready   = 1'b0;
    w_accept     = 1'b0;
    w_load       = 1'b0;
    w_transfer   = 1'b0;
    w_timeout    = 1'b0;
    w_leave_hold = 1'b0;
    w_drop       = 1'b0;
    w_ptr_adv    = 1'b0;
    case (r_state)
      IDLE: begin
        w_in_ready = !rst;
        w_accept   = bus.in_valid && w_in_ready;
        if (w_accept) begin
          if (!bus.rr_mode && w_sel_oob) begin
            w_drop = 1'b1;
          end else begin
            w_load       = 1'b1;
            w_next_state = HOLD;
          end
        end
      end
      HOLD: begin
        w_transfer = |(bus.out_ready & r_out_valid);
        w_timeout  = !w_transfer && (r_wait_cnt == 8'(TIMEOUT-1));
        if (w_transfer || w_timeout) begin
          w_leave_hold = 1'b1;
          w_drop       = w_timeout;
          w_ptr_adv    = r_rr_word;
          w_next_state = IDLE;
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // Capture the accepted word. The target lane and mode are sampled only at accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_data <= '0;
      r_target   <= '0;
      r_rr_word  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_out_data <= bus.in_data;
      end
      if (w_load) begin
        r_target  <= w_req_sel;
        r_rr_word <= bus.rr_mode;
      end
    end
  end

  // One-hot lane valid. It rises the cycle after accept and falls on leaving HOLD.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= '0;
    end else if (w_load) begin
      r_out_valid <= NUM_OUT'(1) << w_req_sel;
    end else if (w_leave_hold) begin
      r_out_valid <= '0;
    end
  end

  // Count stalled HOLD cycles. The count clears whenever HOLD is left.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wait_cnt <= '0;
    end else if ((r_state == HOLD) && !w_leave_hold) begin
      r_wait_cnt <= r_wait_cnt + 8'd1;
    end else begin
      r_wait_cnt <= '0;
    end
  end

  // Round-robin pointer. It moves only when a word taken in RR mode leaves HOLD.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr <= '0;
    end else if (w_ptr_adv) begin
      r_rr_ptr <= w_ptr_inc;
    end
  end

  // Saturating count of words lost to a bad select or a timeout.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_drop_cnt <= '0;
    end else if (w_drop && (r_drop_cnt != 8'hFF)) begin
      r_drop_cnt <= r_drop_cnt + 8'd1;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.cur_sel   = (r_state == HOLD) ? r_target : r_rr_ptr;
  assign bus.busy      = (r_state == HOLD);
  assign bus.drop_cnt  = r_drop_cnt;

`ifdef DISPATCH_STATS_EN
  logic [7:0] r_lane_cnt [NUM_OUT];

  // Per-lane saturating delivery counters. Clear wins over a same-cycle delivery.
  always_ff @(posedge clk) begin
    if (rst || stats_clr) begin
      for (int i = 0; i < NUM_OUT; i++) begin
        r_lane_cnt[i] <= '0;
      end
    end else if (w_transfer) begin
      for (int i = 0; i < NUM_OUT; i++) begin
        if (r_out_valid[i] && (r_lane_cnt[i] != 8'hFF)) begin
          r_lane_cnt[i] <= r_lane_cnt[i] + 8'd1;
        end
      end
    end
  end

  // Flatten the counters onto the lane_cnt bus, with lane 0 in the low byte.
  always_comb begin
    lane_cnt = '0;
    for (int i = 0; i < NUM_OUT; i++) begin
      lane_cnt[i*8 +: 8] = r_lane_cnt[i];
    end
  end
`endif

endmodule

// File: tb/tb_demux_rr_dispatch.sv
// Directed bench for demux_rr_dispatch. It uses a 2-lane instance (dutA) for
// most scenarios and a 3-lane instance (dutB) for the out-of-range select.
// Expected values are hand-derived constants.
module tb_demux_rr_dispatch;

  logic clk;
  logic rst;
  int   errorCount;
  int   checkCount;

  demux_rr_dispatch_if #(.NUM_OUT(2), .DATA_W(8), .SEL_W(1)) busA ();
  demux_rr_dispatch_if #(.NUM_OUT(3), .DATA_W(8), .SEL_W(2)) busB ();

`ifdef DISPATCH_STATS_EN
  logic        statsClrA;
  logic [15:0] laneCntA;
  logic        statsClrB;
  logic [23:0] laneCntB;
`endif

  demux_rr_dispatch #(.NUM_OUT(2), .DATA_W(8), .TIMEOUT(15), .SEL_W(1)) dutA (
    .clk       (clk),
    .rst       (rst),
    .bus       (busA)
`ifdef DISPATCH_STATS_EN
    ,
    .stats_clr (statsClrA),
    .lane_cnt  (laneCntA)
`endif
  );

  demux_rr_dispatch #(.NUM_OUT(3), .DATA_W(8), .TIMEOUT(15), .SEL_W(2)) dutB (
    .clk       (clk),
    .rst       (rst),
    .bus       (busB)
`ifdef DISPATCH_STATS_EN
    ,
    .stats_clr (statsClrB),
    .lane_cnt  (laneCntB)
`endif
  );

  // Free-running clock with a 10-unit period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic stepClock();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic valid, input logic [7:0] data,
                               input logic sel, input logic rrMode);
    busA.in_valid = valid;
    busA.in_data  = data;
    busA.in_sel   = sel;
    busA.rr_mode  = rrMode;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) else begin
      errorCount++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      $error("[TB] %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  logic [1:0] rrLane [3];
  logic [7:0] rrData [3];

  initial begin
    errorCount = 0;
    checkCount = 0;
    rrLane = '{2'b01, 2'b10, 2'b01};
    rrData = '{8'h11, 8'h22, 8'h33};
    rst = 1'b1;
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    busA.out_ready = 2'b00;
    busB.in_valid = 1'b0;
    busB.in_data = 8'h00;
    busB.in_sel = 2'd0;
    busB.rr_mode = 1'b0;
    busB.out_ready = 3'b000;
`ifdef DISPATCH_STATS_EN
    statsClrA = 1'b0;
    statsClrB = 1'b0;
`endif

    // Reset values while rst is high.
    stepClock();
    stepClock();
    checkOutput("rst_in_ready", 32'(busA.in_ready), 32'd0);
    checkOutput("rst_out_valid", 32'(busA.out_valid), 32'd0);
    checkOutput("rst_out_data", 32'(busA.out_data), 32'd0);
    checkOutput("rst_cur_sel", 32'(busA.cur_sel), 32'd0);
    checkOutput("rst_busy", 32'(busA.busy), 32'd0);
    checkOutput("rst_drop_cnt", 32'(busA.drop_cnt), 32'd0);
    rst = 1'b0;
    #1;
    checkOutput("idle_in_ready", 32'(busA.in_ready), 32'd1);

    // Directed word to lane 1 with every lane ready.
    busA.out_ready = 2'b11;
    applyStimulus(1'b1, 8'hA5, 1'b1, 1'b0);
    stepClock();
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("dir_out_valid", 32'(busA.out_valid), 32'h2);
    checkOutput("dir_out_data", 32'(busA.out_data), 32'hA5);
    checkOutput("dir_busy", 32'(busA.busy), 32'd1);
    checkOutput("dir_in_ready", 32'(busA.in_ready), 32'd0);
    checkOutput("dir_cur_sel", 32'(busA.cur_sel), 32'd1);
    stepClock();
    checkOutput("dir_done_valid", 32'(busA.out_valid), 32'd0);
    checkOutput("dir_done_ready", 32'(busA.in_ready), 32'd1);
    checkOutput("dir_done_drop", 32'(busA.drop_cnt), 32'd0);
    checkOutput("dir_ptr_kept", 32'(busA.cur_sel), 32'd0);

    // Round-robin delivers to lanes 0, 1, 0 and the pointer wraps.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, rrData[i], 1'b0, 1'b1);
      stepClock();
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
      checkOutput($sformatf("rr%0d_valid", i), 32'(busA.out_valid), 32'(rrLane[i]));
      checkOutput($sformatf("rr%0d_data", i), 32'(busA.out_data), 32'(rrData[i]));
      stepClock();
    end
    checkOutput("rr_ptr_after", 32'(busA.cur_sel), 32'd1);
    checkOutput("rr_out_data_kept", 32'(busA.out_data), 32'h33);

    // Backpressure: lane 0 stalls 5 cycles, and ready on lane 1 is ignored.
    busA.out_ready = 2'b10;
    applyStimulus(1'b1, 8'h5C, 1'b0, 1'b0);
    stepClock();
    applyStimulus(1'b0, 8'hFF, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      checkOutput($sformatf("bp%0d_valid", i), 32'(busA.out_valid), 32'h1);
      checkOutput($sformatf("bp%0d_in_ready", i), 32'(busA.in_ready), 32'd0);
      checkOutput($sformatf("bp%0d_data", i), 32'(busA.out_data), 32'h5C);
      stepClock();
    end
    busA.out_ready = 2'b01;
    checkOutput("bp5_valid", 32'(busA.out_valid), 32'h1);
    checkOutput("bp5_cur_sel", 32'(busA.cur_sel), 32'd0);
    stepClock();
    checkOutput("bp_done_valid", 32'(busA.out_valid), 32'd0);
    checkOutput("bp_done_drop", 32'(busA.drop_cnt), 32'd0);
    checkOutput("bp_ptr_kept", 32'(busA.cur_sel), 32'd1);

    // Timeout: no ready for 15 HOLD cycles, so the word is dropped.
    busA.out_ready = 2'b00;
    applyStimulus(1'b1, 8'h77, 1'b1, 1'b0);
    stepClock();
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 15; i++) begin
      checkOutput($sformatf("to%0d_valid", i), 32'(busA.out_valid), 32'h2);
      stepClock();
    end
    checkOutput("to_done_valid", 32'(busA.out_valid), 32'd0);
    checkOutput("to_drop_cnt", 32'(busA.drop_cnt), 32'd1);
    checkOutput("to_in_ready", 32'(busA.in_ready), 32'd1);
    checkOutput("to_busy", 32'(busA.busy), 32'd0);

    // Ready arriving on the 15th HOLD cycle transfers the word instead of dropping it.
    applyStimulus(1'b1, 8'h78, 1'b1, 1'b0);
    stepClock();
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 14; i++) begin
      stepClock();
    end
    busA.out_ready = 2'b10;
    checkOutput("to15_valid", 32'(busA.out_valid), 32'h2);
    stepClock();
    busA.out_ready = 2'b00;
    checkOutput("to15_done_valid", 32'(busA.out_valid), 32'd0);
    checkOutput("to15_drop_cnt", 32'(busA.drop_cnt), 32'd1);

    // An RR word that times out still advances the pointer from 1 to 0.
    applyStimulus(1'b1, 8'h44, 1'b0, 1'b1);
    stepClock();
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("rrto_valid", 32'(busA.out_valid), 32'h2);
    for (int i = 0; i < 15; i++) begin
      stepClock();
    end
    checkOutput("rrto_drop_cnt", 32'(busA.drop_cnt), 32'd2);
    checkOutput("rrto_ptr", 32'(busA.cur_sel), 32'd0);

    // Out-of-range select on the 3-lane instance is dropped while it stays in IDLE.
    busB.out_ready = 3'b111;
    busB.in_valid = 1'b1;
    busB.in_sel = 2'd3;
    busB.in_data = 8'h99;
    stepClock();
    busB.in_valid = 1'b0;
    checkOutput("bad_out_valid", 32'(busB.out_valid), 32'd0);
    checkOutput("bad_drop_cnt", 32'(busB.drop_cnt), 32'd1);
    checkOutput("bad_in_ready", 32'(busB.in_ready), 32'd1);
    busB.in_valid = 1'b1;
    busB.in_sel = 2'd2;
    stepClock();
    busB.in_valid = 1'b0;
    checkOutput("lane2_out_valid", 32'(busB.out_valid), 32'h4);

`ifdef DISPATCH_STATS_EN
    // dutA deliveries so far: lane 0 = 3 and lane 1 = 3. A clear zeroes both.
    checkOutput("stats_lane_cnt", 32'(laneCntA), 32'h0303);
    statsClrA = 1'b1;
    stepClock();
    statsClrA = 1'b0;
    checkOutput("stats_cleared", 32'(laneCntA), 32'h0000);
`endif

    // Reset while holding a word loses the word without counting it.
    busA.out_ready = 2'b00;
    applyStimulus(1'b1, 8'h3E, 1'b1, 1'b0);
    stepClock();
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("mid_hold_valid", 32'(busA.out_valid), 32'h2);
    rst = 1'b1;
    stepClock();
    rst = 1'b0;
    checkOutput("mid_rst_valid", 32'(busA.out_valid), 32'd0);
    checkOutput("mid_rst_cur_sel", 32'(busA.cur_sel), 32'd0);
    checkOutput("mid_rst_drop", 32'(busA.drop_cnt), 32'd0);
    checkOutput("mid_rst_busy", 32'(busA.busy), 32'd0);
    #1;
    checkOutput("mid_rst_in_ready", 32'(busA.in_ready), 32'd1);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
